// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions: Tuse/Tnew encodings, MDU latency defaults and
// the RAW hazard predicate used by the stall controller.
package cpu_defs;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // A producer only blocks the consumer when its result arrives later than
  // the consumer needs it; $0 and Tnew==0 fall out of this naturally.
  function automatic logic raw_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] wreg,
                                      input logic [1:0] tnew);
    return (src != 5'd0) && (src == wreg) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// MDU busy tracker: counts down the remaining multiply/divide latency and
// reports busy on the start cycle itself as well as while the count is live.
module md_busy_timer
  import cpu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start,
  input  logic             md_div,
  output logic             md_busy,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  // A new start reloads rather than accumulates: the MDU restarts on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (md_start) begin
      busy_cnt <= md_div ? DIV_LOAD : MULT_LOAD;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  assign md_busy = md_start | (busy_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: freezes PC and F/D and flushes D/E on
// unresolvable RAW hazards or MDU-busy hazards; counts stalled cycles.
module hazard_stall_ctrl
  import cpu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_md_use,
  input  logic [4:0]  e_wreg,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wreg,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_clr,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall;
  logic [CNT_W-1:0] busy_cnt;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (e_md_start),
    .md_div   (e_md_div),
    .md_busy  (md_busy),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    stall_rs = raw_hazard(d_rs, d_tuse_rs, e_wreg, e_tnew) |
               raw_hazard(d_rs, d_tuse_rs, m_wreg, m_tnew);
    stall_rt = raw_hazard(d_rt, d_tuse_rt, e_wreg, e_tnew) |
               raw_hazard(d_rt, d_tuse_rt, m_wreg, m_tnew);
    stall_md = d_md_use & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
  end

  // de_clr is deliberately not forced by reset; D/E clears itself on reset.
  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_clr = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
